// File: rtl/wb_decoder_if.sv
// Master-side request/response bus of wb_decoder; the decoder uses the slave modport,
// the requesting master (or bench) uses the master modport.
interface wb_decoder_if;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wb_decoder.sv
// Bank decoder: routes a single master to NSLAVE slaves by adr_i[31:24] and records the first fault.
// Optional slave-ack timeout (counter + timeout fault) is compiled in with `define WB_DECODER_TIMEOUT_EN.
module wb_decoder #(
    parameter int unsigned NSLAVE  = 4,
    parameter logic [7:0]  BASE    = 8'h00,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_i,
    wb_decoder_if.slave              bus,
    output logic [NSLAVE-1:0]        s_stb_o,
    input  logic [NSLAVE-1:0]        s_ack_i,
    input  logic [32*NSLAVE-1:0]     s_dat_i,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    output logic                     s_we_o,
    output logic                     err_o,
    output logic [31:0]              err_adr_o,
    output logic                     err_to_o,
    input  logic                     err_clr_i
);
    localparam int unsigned SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   dec_sel;
    logic [8:0]      bank_off;
    logic            mapped;
    logic            fault;
    logic [31:0]     s_dat_a [NSLAVE];

    for (genvar i = 0; i < NSLAVE; i++) begin : g_dat
        assign s_dat_a[i] = s_dat_i[32*i +: 32];
    end

    // Nine-bit difference so banks below BASE come out negative and fail the range test.
    assign bank_off = {1'b0, bus.adr_i[31:24]} - {1'b0, BASE};
    assign mapped   = bank_off < 9'(NSLAVE);
    assign dec_sel  = bank_off[SW-1:0];

    assign s_adr_o = bus.adr_i;
    assign s_dat_o = bus.dat_i;
    assign s_sel_o = bus.sel_i;
    assign s_we_o  = bus.we_i;

`ifdef WB_DECODER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        fault_to;
    logic        resp_to_q;
    logic        err_to_q;
    logic [31:0] resp_dat;

    assign resp_dat = resp_to_q ? ERRDATA : 32'h0;
    assign err_to_o = err_to_q;

    always_ff @(posedge clk) begin
        if (rst_i || state_d != WAIT) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            resp_to_q <= 1'b0;
        end else if (fault) begin
            resp_to_q <= fault_to;
        end
    end
`else
    logic [31:0] resp_dat;

    assign resp_dat = 32'h0;
    assign err_to_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        fault      = 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
        fault_to   = 1'b0;
`endif
        s_stb_o    = '0;
        bus.ack_o  = 1'b0;
        bus.dat_o  = '0;
        case (state_q)
            IDLE: begin
                if (bus.stb_i) begin
                    if (mapped) begin
                        s_stb_o[dec_sel] = 1'b1;
                        bus.ack_o        = s_ack_i[dec_sel];
                        bus.dat_o        = s_dat_a[dec_sel];
                        // A same-cycle ack completes the access without leaving IDLE.
                        if (!s_ack_i[dec_sel]) begin
                            state_d = WAIT;
                            sel_d   = dec_sel;
                        end
                    end else begin
                        state_d = RESP;
                        fault   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!bus.stb_i) begin
                    state_d = IDLE;
                end else begin
                    s_stb_o[sel_q] = 1'b1;
                    bus.ack_o      = s_ack_i[sel_q];
                    bus.dat_o      = s_dat_a[sel_q];
                    if (s_ack_i[sel_q]) begin
                        state_d = IDLE;
                    end
`ifdef WB_DECODER_TIMEOUT_EN
                    else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
                        state_d  = RESP;
                        fault    = 1'b1;
                        fault_to = 1'b1;
                    end
`endif
                end
            end
            RESP: begin
                bus.ack_o = bus.stb_i;
                bus.dat_o = resp_dat;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            s_stb_o   = '0;
            bus.ack_o = 1'b0;
            bus.dat_o = '0;
        end
    end

    // A clear in the same cycle as a fault lets the new fault overwrite the held record.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            err_o     <= 1'b0;
            err_adr_o <= '0;
`ifdef WB_DECODER_TIMEOUT_EN
            err_to_q  <= 1'b0;
`endif
        end else if (fault) begin
            err_o <= 1'b1;
            if (!err_o || err_clr_i) begin
                err_adr_o <= bus.adr_i;
`ifdef WB_DECODER_TIMEOUT_EN
                err_to_q  <= fault_to;
`endif
            end
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_decoder.sv
// Directed bench for wb_decoder: expected read data is queued at strobe time and popped on ack_o.
module tb_wb_decoder;
    localparam int unsigned NSLAVE = 4;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [NSLAVE-1:0]      s_stb_o;
    logic [NSLAVE-1:0]      s_ack_i;
    logic [32*NSLAVE-1:0]   s_dat_i;
    logic [31:0]            s_adr_o;
    logic [31:0]            s_dat_o;
    logic [3:0]             s_sel_o;
    logic                   s_we_o;
    logic                   err_o;
    logic [31:0]            err_adr_o;
    logic                   err_to_o;
    logic                   err_clr_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    wb_decoder_if bus ();

    wb_decoder #(
        .NSLAVE (NSLAVE),
        .BASE   (8'h00),
        .TIMEOUT(8),
        .ERRDATA(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .bus      (bus),
        .s_stb_o  (s_stb_o),
        .s_ack_i  (s_ack_i),
        .s_dat_i  (s_dat_i),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .err_o    (err_o),
        .err_adr_o(err_adr_o),
        .err_to_o (err_to_o),
        .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One master access; slave slv acks in cycle 'delay' (never if negative), 'noise' acks from others.
    task automatic access(input string tag, input logic [31:0] adr, input logic we, input int slv,
                          input int delay, input logic [31:0] sdat, input logic [NSLAVE-1:0] noise,
                          input logic clr, input logic [NSLAVE-1:0] exp_stb, input int exp_cycle,
                          input logic [31:0] exp_dat, input int max_cyc);
        int ack_cyc;
        logic [31:0] want;
        ack_cyc = -1;
        if (exp_cycle >= 0) exp_q.push_back(exp_dat);
        for (int i = 0; i < int'(NSLAVE); i++) s_dat_i[32*i +: 32] = 32'hA0000000 + 32'(i);
        if (slv >= 0) s_dat_i[32*slv +: 32] = sdat;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = adr ^ 32'h5A5A5A5A;
        bus.sel_i = 4'hF;
        for (int c = 0; c <= max_cyc && ack_cyc < 0; c++) begin
            s_ack_i   = noise;
            if (slv >= 0 && c == delay) s_ack_i[slv] = 1'b1;
            err_clr_i = (c == 0) ? clr : 1'b0;
            @(negedge clk);
            if (c == 0) begin
                check({tag, "_stb"}, 32'(s_stb_o), 32'(exp_stb));
                check({tag, "_adr"}, s_adr_o, adr);
                check({tag, "_we"}, 32'(s_we_o), 32'(we));
            end
            if (bus.ack_o === 1'b1) begin
                ack_cyc = c;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : ~bus.dat_o;
                check({tag, "_dat"}, bus.dat_o, want);
            end
            next_cycle();
        end
        bus.stb_i = 1'b0;
        s_ack_i   = '0;
        err_clr_i = 1'b0;
        check({tag, "_ackcyc"}, 32'(ack_cyc), 32'(exp_cycle));
    endtask

    task automatic clear_err(input string tag);
        err_clr_i = 1'b1;
        next_cycle();
        err_clr_i = 1'b0;
        @(negedge clk);
        check(tag, 32'(err_o), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst_i     = 1'b1;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.sel_i = '0;
        s_ack_i   = '0;
        s_dat_i   = '0;
        err_clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_err_to", 32'(err_to_o), 32'd0);
        check("rst_err_adr", err_adr_o, 32'd0);
        check("rst_ack", 32'(bus.ack_o), 32'd0);
        check("rst_stb", 32'(s_stb_o), 32'd0);
        next_cycle();

        access("rd_s1", 32'h01000040, 1'b0, 1, 3, 32'h12345678, 4'b0000, 1'b0,
               4'b0010, 3, 32'h12345678, 20);
        check("rd_s1_err", 32'(err_o), 32'd0);

        access("wr_s0_zero", 32'h00000100, 1'b1, 0, 0, 32'hCAFEF00D, 4'b1000, 1'b0,
               4'b0001, 0, 32'hCAFEF00D, 20);

        access("rd_s3_noise", 32'h03FFFFFC, 1'b0, 3, 2, 32'h0BADF00D, 4'b0001, 1'b0,
               4'b1000, 2, 32'h0BADF00D, 20);

        access("unmapped", 32'h7F000010, 1'b0, -1, 0, 32'h0, 4'b0000, 1'b0,
               4'b0000, 1, 32'h0, 5);
        check("unm_err", 32'(err_o), 32'd1);
        check("unm_err_to", 32'(err_to_o), 32'd0);
        check("unm_err_adr", err_adr_o, 32'h7F000010);

        access("bank_edge", 32'h04000000, 1'b0, -1, 0, 32'h0, 4'b0000, 1'b0,
               4'b0000, 1, 32'h0, 5);
        check("sticky_adr", err_adr_o, 32'h7F000010);
        check("sticky_err", 32'(err_o), 32'd1);
        clear_err("clr_err");

        // Abort in WAIT; adr_i changes mid-wait must not move the strobe.
        for (int i = 0; i < int'(NSLAVE); i++) s_dat_i[32*i +: 32] = 32'hA0000000 + 32'(i);
        bus.stb_i = 1'b1;
        bus.adr_i = 32'h02000000;
        next_cycle();
        bus.adr_i = 32'h01000000;
        @(negedge clk);
        check("latch_sel", 32'(s_stb_o), 32'b0100);
        next_cycle();
        next_cycle();
        bus.stb_i = 1'b0;
        @(negedge clk);
        check("abort_stb", 32'(s_stb_o), 32'd0);
        check("abort_ack", 32'(bus.ack_o), 32'd0);
        next_cycle();
        @(negedge clk);
        check("abort_err", 32'(err_o), 32'd0);
        next_cycle();
        access("after_abort", 32'h02000010, 1'b0, 2, 1, 32'h55AA00FF, 4'b0000, 1'b0,
               4'b0100, 1, 32'h55AA00FF, 20);

`ifdef WB_DECODER_TIMEOUT_EN
        access("timeout", 32'h02000080, 1'b0, 2, -1, 32'h0, 4'b0000, 1'b0,
               4'b0100, 9, 32'hDEADBEEF, 20);
        check("to_err", 32'(err_o), 32'd1);
        check("to_err_to", 32'(err_to_o), 32'd1);
        check("to_err_adr", err_adr_o, 32'h02000080);
`else
        access("no_timeout", 32'h02000080, 1'b0, 2, -1, 32'h0, 4'b0000, 1'b0,
               4'b0100, -1, 32'h0, 40);
        check("nto_err", 32'(err_o), 32'd0);
        check("nto_err_to", 32'(err_to_o), 32'd0);
`endif
        next_cycle();
        clear_err("clr_err2");

        access("fault_a", 32'h80000000, 1'b0, -1, 0, 32'h0, 4'b0000, 1'b0,
               4'b0000, 1, 32'h0, 5);
        check("fault_a_adr", err_adr_o, 32'h80000000);
        access("fault_b_clr", 32'h90000004, 1'b0, -1, 0, 32'h0, 4'b0000, 1'b1,
               4'b0000, 1, 32'h0, 5);
        check("clr_vs_fault_err", 32'(err_o), 32'd1);
        check("clr_vs_fault_adr", err_adr_o, 32'h90000004);
        check("clr_vs_fault_to", 32'(err_to_o), 32'd0);

        // Reset while waiting on slave 3 (fourth WAIT cycle).
        bus.stb_i = 1'b1;
        bus.adr_i = 32'h03000020;
        repeat (4) next_cycle();
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_wait_stb", 32'(s_stb_o), 32'd0);
        check("rst_wait_ack", 32'(bus.ack_o), 32'd0);
        next_cycle();
        rst_i     = 1'b0;
        bus.stb_i = 1'b0;
        @(negedge clk);
        check("rst_wait_err", 32'(err_o), 32'd0);
        check("rst_wait_adr", err_adr_o, 32'd0);
        next_cycle();
        access("post_rst", 32'h03000024, 1'b0, 3, 1, 32'h13579BDF, 4'b0000, 1'b0,
               4'b1000, 1, 32'h13579BDF, 20);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_decoder.md
WB_DECODER -- requirements
Module: wb_decoder

Interface
REQ-001 SHALL have parameter NSLAVE, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter BASE, default 8'h00, bank number of slave 0; slave i owns bank BASE+i, where bank = adr_i[31:24].
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for slave ack (1..65535).
REQ-004 SHALL have parameter ERRDATA, default 32'hDEADBEEF, read data returned on a faulted access.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-007 SHALL have ports stb_i/we_i  input  1/1, adr_i  input  32, dat_i  input  32, sel_i  input  4: the master request.
REQ-008 SHALL have ports ack_o  output  1 and dat_o  output  32: the master response.
REQ-009 SHALL have ports s_stb_o  output  NSLAVE, s_ack_i  input  NSLAVE, s_dat_i  input  32*NSLAVE (slave i in bits 32i+31:32i): per-slave strobe, ack and read data.
REQ-010 SHALL have ports s_adr_o  output  32, s_dat_o  output  32, s_sel_o  output  4, s_we_o  output  1: shared pass-through of adr_i, dat_i, sel_i, we_i.
REQ-011 SHALL have ports err_o  output  1 (sticky fault flag), err_adr_o  output  32 (faulting address), err_to_o  output  1 (1 = timeout, 0 = unmapped) and err_clr_i  input  1.

Function
REQ-012 SHALL implement states IDLE, WAIT and RESP; IDLE -> WAIT on stb_i for a mapped bank; IDLE -> RESP on stb_i for an unmapped bank.
REQ-013 SHALL, for a mapped bank, assert s_stb_o[bank-BASE] = stb_i combinationally in IDLE and WAIT, with all other s_stb_o bits 0.
REQ-014 SHALL drive ack_o = s_ack_i[sel] and dat_o = s_dat_i[sel] combinationally during a mapped access, adding zero cycles of latency; on a slave ack the state returns to IDLE.
REQ-015 SHALL ignore s_ack_i from unselected slaves and SHALL drive ack_o = 0 whenever stb_i = 0.
REQ-016 SHALL count, in a 16-bit counter, the cycles spent in WAIT without an ack; the counter clears in IDLE.
REQ-017 SHALL, when the counter reaches TIMEOUT, enter RESP, drop s_stb_o, and set err_o = 1, err_to_o = 1 and err_adr_o = adr_i.
REQ-018 SHALL, in RESP, assert ack_o for exactly one cycle with dat_o = ERRDATA for a timeout or 32'h0 for an unmapped access; writes are discarded; the next state is IDLE.
REQ-019 SHALL, for an unmapped access, set err_o = 1, err_to_o = 0 and err_adr_o = adr_i on entry to RESP.
REQ-020 SHALL update err_adr_o and err_to_o only while err_o = 0, so the first fault is kept until cleared.
REQ-021 SHALL, when err_clr_i and a new fault occur in the same cycle, give the fault priority (err_o stays 1 and captures the new fault).
REQ-022 SHALL abort the access and return to IDLE when stb_i falls in WAIT before an ack, with no error recorded.
REQ-023 SHALL latch the selected slave index on entering WAIT; a change of adr_i during WAIT has no effect until IDLE.

Reset
REQ-024 SHALL, with rst_i = 1, force state IDLE, counter 0, err_o = 0, err_to_o = 0, err_adr_o = 0, ack_o = 0 and s_stb_o = 0, including mid-access; outputs are valid on the first cycle after rst_i falls.

Configuration
REQ-025 SHALL compile the timeout counter and the timeout fault path (REQ-016, REQ-017) only when WB_DECODER_TIMEOUT_EN is defined; without it, WAIT waits indefinitely, err_to_o is tied to 0, and unmapped detection remains.

Verification
REQ-026 SHALL cover: read of bank 8'h01 with slave 1 acking 3 cycles after the strobe with 32'h12345678 -> ack_o in the same cycle as s_ack_i[1], dat_o = 32'h12345678, err_o = 0.
REQ-027 SHALL cover: read of adr 32'h7F000010 -> ack_o one cycle later, dat_o = 0, err_o = 1, err_to_o = 0, err_adr_o = 32'h7F000010.
REQ-028 SHALL cover: TIMEOUT = 8, slave 2 never acks -> ack_o in cycle 9, dat_o = 32'hDEADBEEF, err_to_o = 1 (macro defined); with the macro undefined, no ack ever.
REQ-029 SHALL cover: two successive faults without a clear -> err_adr_o holds the first address; err_clr_i pulse -> err_o = 0.
REQ-030 SHALL cover: rst_i asserted in WAIT cycle 4 -> s_stb_o = 0, state IDLE, and the next access decodes normally.
